// File: rtl/arb_req_client_if.sv
// arb_req_client_if: command, arbiter and beat-bus signals of one
// requester port, grouped for the client and its environment.
interface arb_req_client_if #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 4
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [DATA_W-1:0] cmd_data;
  logic [LEN_W-1:0]  cmd_len;
  logic              req;
  logic              grant;
  logic              bus_valid;
  logic [DATA_W-1:0] bus_data;
  logic              bus_last;
  logic              burst_done;
  logic              starve;

  modport master (
    input  cmd_valid, cmd_data, cmd_len, grant,
    output cmd_ready, req, bus_valid, bus_data,
    output bus_last, burst_done, starve
  );

  modport slave (
    output cmd_valid, cmd_data, cmd_len, grant,
    input  cmd_ready, req, bus_valid, bus_data,
    input  bus_last, burst_done, starve
  );
endinterface

// File: rtl/arb_req_client.sv
// arb_req_client: queues burst commands, requests one arbiter port
// and issues one beat per granted cycle, with a gap after each burst.
module arb_req_client #(
  parameter int DATA_W   = 8,
  parameter int LEN_W    = 4,
  parameter int DEPTH    = 4,
  parameter int WAIT_MAX = 15
) (
  input logic clk,
  input logic rst,
  arb_req_client_if.master io
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int WW = $clog2(WAIT_MAX + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [WW-1:0] WMAX = WW'(WAIT_MAX);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

  state_t state;
  state_t state_nx;

  logic [DATA_W-1:0] mem_data [DEPTH];
  logic [LEN_W-1:0]  mem_len  [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  logic [DATA_W-1:0] base;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  beat_cnt;
  logic [WW-1:0]     wait_cnt;
  logic              req_q;
  logic              done_q;

  logic push;
  logic pop;
  logic beat;
  logic last;

  assign io.cmd_ready  = (count != FULL);
  assign io.req        = req_q;
  assign io.burst_done = done_q;
  assign push = io.cmd_valid && (count != FULL);

  // state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // next-state: pop out of IDLE/GAP, leave REQ on the last beat
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (pop) state_nx = REQ;
      REQ:  if (last) state_nx = GAP;
      GAP:  state_nx = pop ? REQ : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // outputs: beats only while requesting; grant elsewhere is ignored
  always_comb begin
    pop          = 1'b0;
    beat         = 1'b0;
    last         = 1'b0;
    io.bus_valid = 1'b0;
    io.bus_data  = base + DATA_W'(beat_cnt);
    io.bus_last  = 1'b0;
    io.starve    = 1'b0;
    unique case (1'b1)
      state == REQ: begin
        beat         = io.grant;
        last         = io.grant && (beat_cnt == len);
        io.bus_valid = beat;
        io.bus_last  = last;
        io.starve    = (wait_cnt == WMAX);
      end
      default: pop = (count != '0);
    endcase
  end

  // command storage; contents need no reset, pointers gate them
  always_ff @(posedge clk) begin
    if (push) begin
      mem_data[wr_ptr] <= io.cmd_data;
      mem_len[wr_ptr]  <= io.cmd_len;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      unique case (1'b1)
        push && !pop: count <= count + CW'(1);
        pop && !push: count <= count - CW'(1);
        default:      count <= count;
      endcase
    end
  end

  // burst context: loaded on pop, beat counter advances per grant
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      base     <= '0;
      len      <= '0;
      beat_cnt <= '0;
    end else if (pop) begin
      base     <= mem_data[rd_ptr];
      len      <= mem_len[rd_ptr];
      beat_cnt <= '0;
    end else if (beat && !last) begin
      beat_cnt <= beat_cnt + LEN_W'(1);
    end
  end

  // saturating ungranted-cycle counter for starvation
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= '0;
    end else if (pop) begin
      wait_cnt <= '0;
    end else if (state == REQ) begin
      if (io.grant)             wait_cnt <= '0;
      else if (wait_cnt != WMAX) wait_cnt <= wait_cnt + WW'(1);
    end
  end

  // registered req and completion pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      req_q  <= (state_nx == REQ);
      done_q <= last;
    end
  end

endmodule

// File: tb/tb_arb_req_client.sv
// tb_arb_req_client: directed vectors for the requester agent,
// expected values hand-computed.
module tb_arb_req_client;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   failures = 0;

  arb_req_client_if #(.DATA_W(8), .LEN_W(4)) io ();

  arb_req_client #(
    .DATA_W(8), .LEN_W(4), .DEPTH(4), .WAIT_MAX(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .io (io)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  logic       gpat [6];
  logic [7:0] bexp [3];
  int         k;

  initial begin
    io.cmd_valid = 1'b0;
    io.cmd_data  = '0;
    io.cmd_len   = '0;
    io.grant     = 1'b1;

    // reset held with grant high
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_req", io.req, 0);
      chk("rst_bv", io.bus_valid, 0);
      chk("rst_rdy", io.cmd_ready, 1);
      chk("rst_stv", io.starve, 0);
      chk("rst_last", io.bus_last, 0);
      chk("rst_done", io.burst_done, 0);
    end
    rst = 1'b1;
    tick();

    // single burst 10/len2, grant tied high
    io.cmd_valid = 1'b1;
    io.cmd_data  = 8'h10;
    io.cmd_len   = 4'd2;
    tick();
    io.cmd_valid = 1'b0;
    #1 chk("sb_req_e", io.req, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("sb_req", io.req, 1);
      chk("sb_bv", io.bus_valid, 1);
      chk("sb_data", io.bus_data, 32'h10 + i);
      chk("sb_last", io.bus_last, (i == 2));
    end
    tick();
    chk("sb_gap_req", io.req, 0);
    chk("sb_gap_bv", io.bus_valid, 0);
    chk("sb_done", io.burst_done, 1);
    tick();
    chk("sb_idle_req", io.req, 0);
    chk("sb_done0", io.burst_done, 0);

    // intermittent grant 1,0,0,1,0,1
    gpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    bexp = '{8'h10, 8'h11, 8'h12};
    io.grant     = 1'b0;
    io.cmd_valid = 1'b1;
    io.cmd_data  = 8'h10;
    io.cmd_len   = 4'd2;
    tick();
    io.cmd_valid = 1'b0;
    tick();
    k = 0;
    for (int i = 0; i < 6; i++) begin
      io.grant = gpat[i];
      #1;
      chk("ig_req", io.req, 1);
      chk("ig_bv", io.bus_valid, gpat[i]);
      if (gpat[i]) begin
        chk("ig_data", io.bus_data, bexp[k]);
        chk("ig_last", io.bus_last, (k == 2));
        k++;
      end
      tick();
    end
    io.grant = 1'b0;
    #1;
    chk("ig_gap_req", io.req, 0);
    chk("ig_done", io.burst_done, 1);
    tick();

    // back-to-back bursts with data wrap
    io.grant     = 1'b1;
    io.cmd_valid = 1'b1;
    io.cmd_data  = 8'hFE;
    io.cmd_len   = 4'd2;
    tick();
    io.cmd_data = 8'h40;
    io.cmd_len  = 4'd0;
    #1 chk("bb_req0", io.req, 0);
    tick();
    io.cmd_valid = 1'b0;
    bexp = '{8'hFE, 8'hFF, 8'h00};
    for (int i = 0; i < 3; i++) begin
      if (i > 0) tick();
      #1;
      chk("bb_req", io.req, 1);
      chk("bb_data", io.bus_data, bexp[i]);
      chk("bb_last", io.bus_last, (i == 2));
    end
    tick();
    chk("bb_gap_req", io.req, 0);
    chk("bb_gap_bv", io.bus_valid, 0);
    chk("bb_gap_done", io.burst_done, 1);
    tick();
    chk("bb2_req", io.req, 1);
    chk("bb2_data", io.bus_data, 32'h40);
    chk("bb2_last", io.bus_last, 1);
    tick();
    chk("bb2_gap_req", io.req, 0);
    chk("bb2_done", io.burst_done, 1);
    tick();
    chk("bb_idle_req", io.req, 0);
    chk("bb_idle_bv", io.bus_valid, 0);

    // full FIFO while the current burst waits for grant
    io.grant     = 1'b0;
    io.cmd_len   = 4'd0;
    io.cmd_valid = 1'b1;
    io.cmd_data  = 8'h20;
    tick();
    io.cmd_valid = 1'b0;
    tick();
    for (int i = 1; i <= 4; i++) begin
      io.cmd_valid = 1'b1;
      io.cmd_data  = 8'(8'h20 + i);
      #1 chk("ff_rdy", io.cmd_ready, 1);
      tick();
    end
    io.cmd_data = 8'h25;
    #1 chk("ff_full", io.cmd_ready, 0);
    tick();
    chk("ff_full2", io.cmd_ready, 0);
    io.grant = 1'b1;
    #1;
    chk("ff_a_data", io.bus_data, 32'h20);
    chk("ff_a_last", io.bus_last, 1);
    tick();
    io.grant = 1'b0;
    #1;
    chk("ff_gap_req", io.req, 0);
    chk("ff_gap_rdy", io.cmd_ready, 0);
    tick();
    chk("ff_pop_rdy", io.cmd_ready, 1);
    tick();
    io.cmd_valid = 1'b0;
    for (int j = 1; j <= 5; j++) begin
      io.grant = 1'b1;
      #1;
      chk("ff_dr_bv", io.bus_valid, 1);
      chk("ff_dr_data", io.bus_data, 32'h20 + j);
      chk("ff_dr_last", io.bus_last, 1);
      tick();
      chk("ff_dr_gap", io.req, 0);
      tick();
    end
    io.grant = 1'b0;
    #1;
    chk("ff_idle_req", io.req, 0);
    chk("ff_idle_rdy", io.cmd_ready, 1);

    // starvation with WAIT_MAX=3, then reset mid-burst
    io.cmd_valid = 1'b1;
    io.cmd_data  = 8'h50;
    io.cmd_len   = 4'd1;
    tick();
    io.cmd_valid = 1'b0;
    tick();
    for (int c = 1; c <= 4; c++) begin
      #1;
      chk("sv_req", io.req, 1);
      chk("sv_starve", io.starve, (c == 4));
      tick();
    end
    io.grant = 1'b1;
    #1;
    chk("sv_starve_g", io.starve, 1);
    chk("sv_data", io.bus_data, 32'h50);
    chk("sv_last", io.bus_last, 0);
    tick();
    io.grant     = 1'b0;
    io.cmd_valid = 1'b1;
    io.cmd_data  = 8'h60;
    io.cmd_len   = 4'd0;
    #1 chk("sv_clear", io.starve, 0);
    tick();
    io.cmd_valid = 1'b0;
    io.grant     = 1'b1;
    rst          = 1'b0;
    #1;
    chk("mr_req", io.req, 0);
    chk("mr_bv", io.bus_valid, 0);
    chk("mr_last", io.bus_last, 0);
    chk("mr_rdy", io.cmd_ready, 1);
    chk("mr_stv", io.starve, 0);
    chk("mr_done", io.burst_done, 0);
    tick();
    tick();
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("pr_req", io.req, 0);
      chk("pr_bv", io.bus_valid, 0);
      chk("pr_rdy", io.cmd_ready, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
